// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, data width and sequencer state encoding shared by the
// ALU sequencer, its register file and any parent that instantiates the ALU.
package alu_pkg;
    localparam int DW = 32;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SRL  = 3'd4;
    localparam logic [2:0] OP_SRA  = 3'd5;
    localparam logic [2:0] OP_LAST = 3'd5;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x 32 register file, two operand reads plus a debug
// read, one synchronous write, async active-low clear; r0 is hardwired to 0.
module alu_seq_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            regs <= '{default: '0};
        else if (we && waddr != '0)
            regs[waddr] <= wdata;

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: single-command sequencer that reads operands, drives an external
// combinational ALU, captures and writes back its result and returns it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic          cmd_imm_en,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_c,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_rd,
    output logic          rsp_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    state_t        state, state_nx;
    logic [DW-1:0] rs_data, rt_data;
    logic          accept, wr_en;

    assign accept = cmd_valid && cmd_ready;
    assign wr_en  = state == CAPT && !rsp_err;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = ISSUE;
            end
            ISSUE: state_nx = CAPT;
            CAPT:  state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
        endcase
    end

    // rsp_rd/rsp_err are latched at accept; they only become visible with rsp_valid.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= rs_data;
                alu_b   <= cmd_imm_en ? cmd_imm : rt_data;
                alu_op  <= cmd_op;
                rsp_rd  <= cmd_rd;
                rsp_err <= cmd_op > OP_LAST;
            end
            if (state == CAPT) begin
                rsp_data  <= rsp_err ? '0 : alu_c;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end

    alu_seq_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .waddr    (rsp_rd),
        .wdata    (alu_c),
        .raddr_a  (cmd_rs),
        .rdata_a  (rs_data),
        .raddr_b  (cmd_rt),
        .rdata_b  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );
endmodule
